ysyx_23060025_axi_rd_responder: RTL
===================================

// Module: ysyx_23060025_axi_rd_responder
// PURPOSE
//  AXI4 read-only burst responder (slave) backed by a word-addressed SRAM array; the memory-side end of the
//  icache refill path. Accepts one AR request at a time, waits a fixed latency, then returns arlen+1 R beats.
//  Used as the DRAM model in NPC sim and as a refill target for icache/dcache benches. Write path = backdoor only.
// PARAMETERS
//  ADDR_WIDTH   32            address width
//  DATA_WIDTH   32            R data width (one word per beat)
//  MEM_DEPTH_W  12            log2(number of words in array)
//  BASE_ADDR    32'h8000_0000 byte address of word 0
//  LATENCY      2             cycles from AR handshake to first rvalid (>=1)
// PORTS
//  clock        in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  in_araddr    in   32  burst start byte address
//  in_arvalid   in   1   AR valid
//  in_arready   out  1   AR ready
//  in_arlen     in   8   beats-1
//  in_arsize    in   3   beat size; only AXI_ADDR_SIZE_4 (3'b010) legal
//  in_arburst   in   2   only FIXED (2'b00) / AXI_ADDR_BURST_INCR (2'b01) legal
//  in_rvalid    out  1   R valid
//  in_rdata     out  32  R data
//  in_rresp     out  2   00 OKAY, 10 SLVERR, 11 DECERR
//  in_rlast     out  1   final beat of burst
//  in_rready    in   1   R ready
//  bd_wen       in   1   backdoor word write enable (test/preload)
//  bd_waddr     in   MEM_DEPTH_W  backdoor word index
//  bd_wdata     in   32  backdoor data
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; in_arready=1; in_rvalid=0; in_rlast=0; in_rdata=0; in_rresp=0; counters=0.
//  Array contents are not reset.
//  States: IDLE -> LAT -> DATA -> (GAP ->) DATA ... -> IDLE.
//   IDLE: arready=1; arvalid&arready latches addr/len/size/burst, beat_cnt=0, lat_cnt=LATENCY-1 -> LAT.
//   LAT : arready=0; lat_cnt decrements; at 0 -> DATA (first rvalid exactly LATENCY cycles after AR handshake).
//   DATA: rvalid=1; rdata/rresp/rlast held stable until rready. On rvalid&rready: if beat_cnt==len -> IDLE,
//         else beat_cnt+1, addr advances -> DATA (back-to-back beats, 1 beat/cycle) or GAP (see CONFIGURATION).
//  Address: byte addr[1:0] ignored (word aligned). INCR: addr+=4 per beat; FIXED: addr constant.
//   word index = (addr-BASE_ADDR)>>2, MEM_DEPTH_W bits; beat out of [BASE_ADDR, BASE_ADDR+4*2^MEM_DEPTH_W)
//   -> rresp=DECERR, rdata=0; other beats of same burst unaffected.
//  Illegal size or WRAP/reserved burst: all len+1 beats returned with rresp=SLVERR, rdata=0; rlast still on final beat.
//  rlast=1 iff rvalid & beat_cnt==len. arlen=0 -> single beat with rlast=1. arlen=255 -> 256 beats, no counter wrap.
//  No outstanding-request queue: arready=0 outside IDLE; arvalid held by master is accepted on return to IDLE
//  (earliest cycle after final beat handshake).
//  Backdoor write: sync write on clock when bd_wen; same-cycle read of same word returns OLD data; allowed any state.
//  Reset asserted mid-burst: burst abandoned immediately, rvalid drops asynchronously, no further beats.
// CONFIGURATION
//  YSYX_23060025_AXI_RAND_DELAY_EN defined: after each non-final beat handshake, 16-bit LFSR (seed 16'hACE1 on reset)
//   low 2 bits give GAP length 0..3 cycles with rvalid=0; LFSR advances once per handshake. Stresses master rready/rvalid.
//  Undefined: no GAP state; beats strictly back-to-back while rready=1.
// STRUCTURE
//  Shared defines (ysyx_23060025_define.v): AXI_ADDR_SIZE_4, AXI_ADDR_BURST_INCR/FIXED, new AXI_RESP_OKAY/SLVERR/DECERR.
//  Sub-module: ysyx_23060025_lfsr16 (enable, seed, q) instantiated only under YSYX_23060025_AXI_RAND_DELAY_EN.
//  Array + FSM + address generator stay in this module.
// TESTING
//  T1 preload words 0..3 = 0x11,0x22,0x33,0x44; AR 0x8000_0000 len=3 INCR size4, rready=1 -> rvalid first at
//     handshake+2, beats 0x11,0x22,0x33,0x44 OKAY, rlast on 4th only, arready back 1 next cycle.
//  T2 same burst, rready toggled 1,0,0,1,... -> each beat's rdata/rresp/rlast stable while rready=0; no beat lost/duplicated.
//  T3 AR 0x8000_3FF8 len=3 (MEM_DEPTH_W=12) -> beats 0,1 OKAY with data, beats 2,3 DECERR rdata=0.
//  T4 AR arburst=WRAP len=1 -> 2 beats SLVERR rdata=0, rlast on 2nd; arsize=3'b011 len=0 -> 1 beat SLVERR rlast=1.
//  T5 FIXED len=2 at word 5=0xDEAD -> three beats 0xDEAD; arvalid held high during burst -> accepted only after final beat.
//  T6 reset low during beat 2 of len=7 -> rvalid=0 same cycle, arready=1 after release; new AR served normally.

Source files
------------

// File: rtl/ysyx_23060025_axi_rd_responder_pkg.sv
// Shared AXI encodings and FSM state type for the read responder.
package ysyx_23060025_axi_rd_responder_pkg;

    localparam logic [2:0] AXI_ADDR_SIZE_4       = 3'b010;
    localparam logic [1:0] AXI_ADDR_BURST_FIXED  = 2'b00;
    localparam logic [1:0] AXI_ADDR_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY         = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR       = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR       = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAT,
        ST_DATA,
        ST_GAP
    } state_t;

    function automatic logic req_legal(input logic [2:0] size, input logic [1:0] burst);
        return (size == AXI_ADDR_SIZE_4) &&
               ((burst == AXI_ADDR_BURST_FIXED) || (burst == AXI_ADDR_BURST_INCR));
    endfunction

endpackage

// File: rtl/ysyx_23060025_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11), loads seed on reset, steps once per enable.
// Single-cycle update; no backpressure.
module ysyx_23060025_lfsr16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= seed;
        end else if (enable) begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/ysyx_23060025_axi_rd_responder.sv
// AXI4 read burst responder over a backdoor-loaded SRAM; first beat LATENCY cycles after AR, then 1 beat/cycle.
// R beat held stable until rready, one request at a time; YSYX_23060025_AXI_RAND_DELAY_EN adds 0..3-cycle LFSR gaps.
module ysyx_23060025_axi_rd_responder
    import ysyx_23060025_axi_rd_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH_W = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    LATENCY     = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  in_araddr,
    input  logic                   in_arvalid,
    output logic                   in_arready,
    input  logic [7:0]             in_arlen,
    input  logic [2:0]             in_arsize,
    input  logic [1:0]             in_arburst,
    output logic                   in_rvalid,
    output logic [DATA_WIDTH-1:0]  in_rdata,
    output logic [1:0]             in_rresp,
    output logic                   in_rlast,
    input  logic                   in_rready,
    input  logic                   bd_wen,
    input  logic [MEM_DEPTH_W-1:0] bd_waddr,
    input  logic [DATA_WIDTH-1:0]  bd_wdata
);

    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WA_W-1:0] BASE_W = BASE_ADDR[ADDR_WIDTH-1:2];

    logic [DATA_WIDTH-1:0] mem [2**MEM_DEPTH_W];

    state_t          state;
    logic [WA_W-1:0] addr_w;
    logic [7:0]      len;
    logic [7:0]      beat_cnt;
    logic            incr;
    logic            legal;
    logic [LAT_W-1:0] lat_cnt;

    logic [WA_W-1:0]       nxt_addr_w;
    logic [WA_W-1:0]       fetch_w;
    logic [WA_W-1:0]       off_w;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic [1:0]            fetch_resp;
    logic                  beat_done;
    logic                  more_beats;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^in_araddr[1:0];

    assign beat_done  = (state == ST_DATA) && in_rvalid && in_rready;
    assign more_beats = (beat_cnt != len);
    assign nxt_addr_w = incr ? addr_w + WA_W'(1) : addr_w;

    // In DATA the word being fetched is the one after the current beat; in LAT/GAP addr_w already points at it.
    assign fetch_w  = (state == ST_DATA) ? nxt_addr_w : addr_w;
    assign off_w    = fetch_w - BASE_W;
    assign in_range = (off_w[WA_W-1:MEM_DEPTH_W] == '0);

    always_comb begin
        fetch_data = '0;
        fetch_resp = AXI_RESP_OKAY;
        if (!legal) begin
            fetch_resp = AXI_RESP_SLVERR;
        end else if (!in_range) begin
            fetch_resp = AXI_RESP_DECERR;
        end else begin
            fetch_data = mem[off_w[MEM_DEPTH_W-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (bd_wen) begin
            mem[bd_waddr] <= bd_wdata;
        end
    end

`ifdef YSYX_23060025_AXI_RAND_DELAY_EN
    logic [15:0] lfsr_q;
    logic [1:0]  gap_cnt;

    ysyx_23060025_lfsr16 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (beat_done && more_beats),
        .seed   (16'hACE1),
        .q      (lfsr_q)
    );
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            in_arready <= 1'b1;
            in_rvalid  <= 1'b0;
            in_rlast   <= 1'b0;
            in_rdata   <= '0;
            in_rresp   <= AXI_RESP_OKAY;
            addr_w     <= '0;
            len        <= '0;
            beat_cnt   <= '0;
            incr       <= 1'b0;
            legal      <= 1'b0;
            lat_cnt    <= '0;
`ifdef YSYX_23060025_AXI_RAND_DELAY_EN
            gap_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_arvalid && in_arready) begin
                        addr_w     <= in_araddr[ADDR_WIDTH-1:2];
                        len        <= in_arlen;
                        incr       <= (in_arburst == AXI_ADDR_BURST_INCR);
                        legal      <= req_legal(in_arsize, in_arburst);
                        beat_cnt   <= '0;
                        lat_cnt    <= LAT_W'(LATENCY - 1);
                        in_arready <= 1'b0;
                        state      <= ST_LAT;
                    end
                end
                ST_LAT: begin
                    if (lat_cnt == '0) begin
                        in_rvalid <= 1'b1;
                        in_rdata  <= fetch_data;
                        in_rresp  <= fetch_resp;
                        in_rlast  <= (len == 8'd0);
                        state     <= ST_DATA;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (beat_done) begin
                        if (!more_beats) begin
                            in_rvalid  <= 1'b0;
                            in_rlast   <= 1'b0;
                            in_arready <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                            addr_w   <= nxt_addr_w;
`ifdef YSYX_23060025_AXI_RAND_DELAY_EN
                            if (lfsr_q[1:0] != 2'd0) begin
                                in_rvalid <= 1'b0;
                                in_rlast  <= 1'b0;
                                gap_cnt   <= lfsr_q[1:0] - 2'd1;
                                state     <= ST_GAP;
                            end else begin
                                in_rdata <= fetch_data;
                                in_rresp <= fetch_resp;
                                in_rlast <= (beat_cnt + 8'd1 == len);
                            end
`else
                            in_rdata <= fetch_data;
                            in_rresp <= fetch_resp;
                            in_rlast <= (beat_cnt + 8'd1 == len);
`endif
                        end
                    end
                end
                ST_GAP: begin
`ifdef YSYX_23060025_AXI_RAND_DELAY_EN
                    if (gap_cnt == 2'd0) begin
                        in_rvalid <= 1'b1;
                        in_rdata  <= fetch_data;
                        in_rresp  <= fetch_resp;
                        in_rlast  <= (beat_cnt == len);
                        state     <= ST_DATA;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
